// File: rtl/addac_param.sv
// rtl/addac_param.sv - WIDTH-generic accumulator ALU with LOAD/ADD/SUB/MAC
//
// Purpose:
//   Holds a WIDTH-bit accumulator. Ops arrive through a valid/ready handshake.
//   LOAD, ADD and SUB finish at the accept edge. MAC runs a shift-add multiply
//   over WIDTH cycles and then adds the truncated product in one more cycle.
//   Build option: define ADDAC_SAT_EN to clamp the accumulator on signed
//   overflow. By default the accumulator wraps in two's complement.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active-high
//   in_valid   in   op/a/b are valid this cycle
//   in_ready   out  block can accept an op this cycle
//   op         in   00 LOAD, 01 ADD, 10 SUB, 11 MAC
//   a          in   operand A
//   b          in   operand B (MAC only)
//   acc_out    out  accumulator register
//   out_valid  out  one-cycle pulse when acc_out/flags hold a new result
//   carry      out  carry-out of the last add/sub (SUB: 1 = no borrow)
//   ovf        out  signed overflow of the last add/sub/MAC add
//   zero       out  acc_out == 0
module addac_param #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc_out,
  output logic             out_valid,
  output logic             carry,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_MAC  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ACC  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q, b_q, prod;
  logic [CW-1:0]    cnt;
  logic             mul_last;

  logic             accept;
  logic             acc_we;
  logic             is_load;
  logic             mac_start;

  logic [WIDTH-1:0] add_y;
  logic             add_cin;
  logic [WIDTH:0]   sum;
  logic             sum_ovf;
  logic [WIDTH-1:0] result;

  // in_ready is forced low during reset so nothing is accepted while rst is high.
  assign in_ready = (state == S_IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign zero     = (acc_out == '0);
  assign mul_last = (cnt == CW'(WIDTH - 1));

  // Next-state and datapath control.
  always_comb begin
    state_nxt = state;
    acc_we    = 1'b0;
    is_load   = 1'b0;
    mac_start = 1'b0;
    add_y     = a;
    add_cin   = 1'b0;
    case (state)
      S_IDLE: begin
        // SUB is acc + ~a + 1 so the same adder and flag logic serve both.
        if (op == OP_SUB) begin
          add_y   = ~a;
          add_cin = 1'b1;
        end
        if (accept) begin
          if (op == OP_MAC) begin
            mac_start = 1'b1;
            state_nxt = S_MUL;
          end else begin
            acc_we  = 1'b1;
            is_load = (op == OP_LOAD);
          end
        end
      end
      S_MUL: begin
        if (mul_last) state_nxt = S_ACC;
      end
      S_ACC: begin
        add_y     = prod;
        acc_we    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // One shared WIDTH+1 bit adder; the top bit is the carry-out.
  assign sum     = {1'b0, acc_out} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
  assign sum_ovf = (acc_out[WIDTH-1] == add_y[WIDTH-1]) &&
                   (sum[WIDTH-1] != acc_out[WIDTH-1]);

`ifdef ADDAC_SAT_EN
  // Overflow only happens when both operands share a sign, so the
  // accumulator's sign tells which rail to clamp to.
  always_comb begin
    result = sum[WIDTH-1:0];
    if (sum_ovf) begin
      if (acc_out[WIDTH-1]) result = {1'b1, {(WIDTH-1){1'b0}}};
      else                  result = {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign result = sum[WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      acc_out   <= '0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      prod      <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= acc_we;

      if (acc_we) begin
        if (is_load) begin
          acc_out <= a;
          carry   <= 1'b0;
          ovf     <= 1'b0;
        end else begin
          acc_out <= result;
          carry   <= sum[WIDTH];
          ovf     <= sum_ovf;
        end
      end

      if (mac_start) begin
        a_q  <= a;
        b_q  <= b;
        prod <= '0;
        cnt  <= '0;
      end else if (state == S_MUL) begin
        // Shift-add multiply; bits above WIDTH fall off the product.
        if (b_q[cnt]) prod <= prod + (a_q << cnt);
        cnt <= mul_last ? '0 : cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_addac_param.sv
// tb/tb_addac_param.sv - self-checking bench for addac_param (WIDTH=4)
module tb_addac_param;

  localparam int W = 4;
  localparam int M = 1 << W;

  localparam logic [1:0] LOAD = 2'b00;
  localparam logic [1:0] ADD  = 2'b01;
  localparam logic [1:0] SUB  = 2'b10;
  localparam logic [1:0] MAC  = 2'b11;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] acc_out;
  logic         out_valid;
  logic         carry;
  logic         ovf;
  logic         zero;

  int checks = 0;
  int errors = 0;

  int macc   = 0;
  int mcarry = 0;
  int movf   = 0;

  addac_param #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .acc_out   (acc_out),
    .out_valid (out_valid),
    .carry     (carry),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sgn(input int v);
    return (v >= M / 2) ? 1 : 0;
  endfunction

  // Reference model: integer arithmetic on the architectural rules.
  task automatic model_step(input logic [1:0] o, input int x, input int y);
    int opnd, s, r;
    if (o == LOAD) begin
      macc = x; mcarry = 0; movf = 0;
      return;
    end
    if (o == ADD) begin
      opnd = x;            s = macc + opnd;
    end else if (o == SUB) begin
      opnd = (M - 1) - x;  s = macc + opnd + 1;
    end else begin
      opnd = (x * y) % M;  s = macc + opnd;
    end
    mcarry = (s >= M) ? 1 : 0;
    r      = s % M;
    movf   = (sgn(macc) == sgn(opnd) && sgn(r) != sgn(macc)) ? 1 : 0;
`ifdef ADDAC_SAT_EN
    if (movf == 1) r = (sgn(macc) == 1) ? M / 2 : M / 2 - 1;
`endif
    macc = r;
  endtask

  task automatic check_result(input string tag);
    check({tag, "_acc"},   acc_out, macc);
    check({tag, "_carry"}, carry,   mcarry);
    check({tag, "_ovf"},   ovf,     movf);
    check({tag, "_zero"},  zero,    (macc == 0) ? 1 : 0);
  endtask

  // Offer one op, wait for accept, then wait for its result pulse.
  task automatic do_op(input string tag, input logic [1:0] o, input int x, input int y);
    int n;
    op = o; a = W'(x); b = W'(y); in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_accept_timeout"}, (n < 50) ? 1 : 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_step(o, x, y);
    if (o == MAC) begin
      n = 0;
      while (!out_valid && n < 50) begin
        check({tag, "_busy_ready"}, in_ready, 0);
        @(posedge clk); #1; n++;
      end
      check({tag, "_mac_cycles"}, n, W + 1);
    end
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_in_ready"},  in_ready,  1);
    check_result(tag);
  endtask

  initial begin
    int n;
    int lat;
    rst = 1'b1; in_valid = 1'b0; op = LOAD; a = '0; b = '0;

    // Reset
    @(posedge clk); @(posedge clk); #1;
    check("rst_acc",       acc_out,   0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready,  0);
    check("rst_carry",     carry,     0);
    check("rst_ovf",       ovf,       0);
    check("rst_zero",      zero,      1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", in_ready,  1);
    check("post_rst_valid", out_valid, 0);

    // 1: LOAD 5, single-cycle pulse
    do_op("load5", LOAD, 5, 0);
    @(posedge clk); #1;
    check("load5_pulse_end", out_valid, 0);

    // 2: SUB 5 then back-to-back ADD 3
    op = SUB; a = 4'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    model_step(SUB, 5, 0);
    check("sub5_out_valid", out_valid, 1);
    check_result("sub5");
    op = ADD; a = 4'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_step(ADD, 3, 0);
    check("b2b_add_out_valid", out_valid, 1);
    check_result("b2b_add3");

    // 3: signed overflow 7 + 1
    do_op("load7", LOAD, 7, 0);
    do_op("ovf_add1", ADD, 1, 0);

    // 4: MAC 2 + 3*3
    do_op("load2", LOAD, 2, 0);
    do_op("mac33", MAC, 3, 3);
    @(posedge clk); #1;
    check("mac33_pulse_end", out_valid, 0);

    // 5: reset during MUL
    do_op("load6", LOAD, 6, 0);
    op = MAC; a = 4'd3; b = 4'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    macc = 0; mcarry = 0; movf = 0;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready",  in_ready,  0);
    check_result("abort");
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_ready_after", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      check("abort_no_pulse", out_valid, 0);
      @(posedge clk); #1;
    end

    // 6: ADD held valid through a MAC
    do_op("load1", LOAD, 1, 0);
    op = MAC; a = 4'd5; b = 4'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    op = ADD; a = 4'd1; b = 4'd0;
    n = 0;
    while (!in_ready && n < 50) begin
      check("held_no_pulse", out_valid, 0);
      @(posedge clk); #1; n++;
    end
    check("held_mac_cycles", n, W + 1);
    model_step(MAC, 5, 3);
    check("held_mac_valid", out_valid, 1);
    check_result("held_mac");
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_step(ADD, 1, 0);
    check("held_add_valid", out_valid, 1);
    check_result("held_add");
    @(posedge clk); #1;
    check("held_pulse_end", out_valid, 0);

    // Randomized ops against the model
    for (int i = 0; i < 150; i++) begin
      do_op("rand", 2'($urandom_range(0, 3)), $urandom_range(0, M - 1), $urandom_range(0, M - 1));
      lat = $urandom_range(0, 2);
      for (int k = 0; k < lat; k++) begin
        @(posedge clk); #1;
        check("rand_idle_valid", out_valid, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
